// File: rtl/custom_arith_pkg.sv
// Shared arithmetic package for the FP datapath adder/subtractor family.
// Holds the sequencer state encoding, default operand widths and the
// helpers that size the chunk counter from the operand/chunk widths.
package custom_arith_pkg;

    // Default widths shared with the 54+9 mantissa/exponent adder.
    localparam int DEF_A_WIDTH = 54;
    localparam int DEF_B_WIDTH = 9;
    localparam int DEF_CHUNK   = 9;

    // Sequencer states for the multi-cycle arithmetic blocks.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of CHUNK-wide slices in an A_WIDTH operand.
    function automatic int calc_num_chunks(input int a_width, input int chunk);
        return a_width / chunk;
    endfunction

    // Width of a counter that indexes every chunk (never narrower than 1 bit).
    function automatic int calc_idx_width(input int num_chunks);
        return (num_chunks <= 1) ? 1 : $clog2(num_chunks);
    endfunction

endpackage

// File: rtl/custom_subtractor54_9_seq_chunk.sv
// One CHUNK-bit slice of an unsigned ripple-borrow subtractor.
// Purely combinational: {bout, d} = a - b - bin, computed CHUNK+1 bits wide
// so bit CHUNK of the result is the borrow-out into the next slice.
module unsignedRippleBorrowSubtractorChunk #(
    parameter int CHUNK = 9
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    logic [CHUNK:0] w_full;

    // Extended subtraction; a negative result wraps so that bit CHUNK is set.
    always_comb begin
        w_full = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};
        d      = w_full[CHUNK-1:0];
        bout   = w_full[CHUNK];
    end

endmodule

// File: rtl/custom_subtractor54_9_seq.sv
// Multi-cycle unsigned subtractor: Diff = A - zero_extend(B).
// Processes CHUNK bits per BUSY cycle through a single time-multiplexed
// slice, carrying the borrow between cycles in a register.
// Optional build macro: CUSTOM_SUB_SATURATE_EN -- when defined, a final
// borrow forces Diff to 0 (Borrow stays 1, Zero becomes 1).
//
// Handshake: an operand pair transfers on a rising edge where
// in_valid && in_ready; a result transfers on a rising edge where
// out_valid && out_ready. in_ready is high only in IDLE, out_valid only in
// DONE, and the result outputs are held unchanged while out_valid is high
// and out_ready is low. in_valid is ignored outside IDLE.
module custom_subtractor54_9_seq
    import custom_arith_pkg::*;
#(
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int B_WIDTH = DEF_B_WIDTH,
    parameter int CHUNK   = DEF_CHUNK
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_WIDTH-1:0] Diff,
    output logic               Borrow,
    output logic               Zero,
    output state_e             o_dbg_state
);

    localparam int NUM_CHUNKS = calc_num_chunks(A_WIDTH, CHUNK);
    localparam int IDX_W      = calc_idx_width(NUM_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    // Reject configurations the chunked datapath cannot cover exactly.
    generate
        if (CHUNK < 1 || (A_WIDTH % CHUNK) != 0 || B_WIDTH > A_WIDTH) begin : g_bad_cfg
            $error("custom_subtractor54_9_seq: CHUNK must divide A_WIDTH and B_WIDTH must not exceed A_WIDTH");
        end
    endgenerate

    // Sequencer and datapath state.
    state_e             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [A_WIDTH-1:0] r_a;
    logic [A_WIDTH-1:0] r_b;
    logic [A_WIDTH-1:0] r_diff;
    logic               r_borrow_chain;
    logic               r_nonzero;
    logic               r_borrow;
    logic               r_zero;
    logic               r_in_ready;
    logic               r_out_valid;

    // Current slice operands/results.
    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK-1:0]   w_d;
    logic               w_bout;
    logic               w_last;
    logic               w_final_zero;
    int                 w_base;

    // Select the slice addressed by the chunk counter from the latched operands.
    always_comb begin
        w_base    = int'(r_idx) * CHUNK;
        w_a_chunk = r_a[w_base +: CHUNK];
        w_b_chunk = r_b[w_base +: CHUNK];
        w_last    = (r_idx == LAST_IDX);
        // Zero is tracked incrementally so the final cycle only ORs one slice.
        w_final_zero = ~(r_nonzero | (|w_d));
    end

    unsignedRippleBorrowSubtractorChunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (w_a_chunk),
        .b    (w_b_chunk),
        .bin  (r_borrow_chain),
        .d    (w_d),
        .bout (w_bout)
    );

    // Sequencer: accept operands, ripple one slice per cycle, hold the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_diff         <= '0;
            r_borrow_chain <= 1'b0;
            r_nonzero      <= 1'b0;
            r_borrow       <= 1'b0;
            r_zero         <= 1'b0;
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a            <= A;
                        r_b            <= A_WIDTH'(B);
                        r_borrow_chain <= 1'b0;
                        r_nonzero      <= 1'b0;
                        r_idx          <= '0;
                        r_in_ready     <= 1'b0;
                        r_state        <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    r_diff[w_base +: CHUNK] <= w_d;
                    r_borrow_chain          <= w_bout;
                    r_nonzero               <= r_nonzero | (|w_d);
                    if (w_last) begin
                        r_idx       <= '0;
                        r_borrow    <= w_bout;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
`ifdef CUSTOM_SUB_SATURATE_EN
                        // Underflow clamps the result to zero.
                        if (w_bout) begin
                            r_diff <= '0;
                            r_zero <= 1'b1;
                        end else begin
                            r_zero <= w_final_zero;
                        end
`else
                        r_zero <= w_final_zero;
`endif
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end

                ST_DONE: begin
                    // No accept on the release edge; in_ready rises next cycle.
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_idx       <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign Diff        = r_diff;
    assign Borrow      = r_borrow;
    assign Zero        = r_zero;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_custom_subtractor54_9_seq.sv
// Self-checking bench for custom_subtractor54_9_seq (default 54/9/9 build).
module tb_custom_subtractor54_9_seq;

  localparam int AW  = 54;
  localparam int BW  = 9;
  localparam int NCH = AW / 9;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] A;
  logic [BW-1:0] B;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] Diff;
  logic          Borrow;
  logic          Zero;
  logic [1:0]    dbg_state;

  custom_subtractor54_9_seq dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .A           (A),
    .B           (B),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .Diff        (Diff),
    .Borrow      (Borrow),
    .Zero        (Zero),
    .o_dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries: {borrow, zero, diff}
  logic [AW+1:0] exp_q[$];

  // Reference: plain unsigned arithmetic on the whole operands.
  function automatic logic [AW+1:0] ref_model(input logic [AW-1:0] a, input logic [BW-1:0] b);
    logic [AW-1:0] bext;
    logic [AW-1:0] d;
    logic          bo;
    logic          z;
    bext = AW'(b);
    bo   = (a < bext);
    d    = a - bext;
`ifdef CUSTOM_SUB_SATURATE_EN
    if (bo) d = '0;
`endif
    z = (d == '0);
    return {bo, z, d};
  endfunction

  function automatic logic [AW-1:0] rand_a();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[AW-1:0];
  endfunction

  // Driver: one full transaction with optional result backpressure.
  task automatic run_op(input logic [AW-1:0] a, input logic [BW-1:0] b, input int stall,
                        output logic [AW-1:0] d, output logic bo, output logic z,
                        output int lat, output logic post_rdy, output logic post_vld);
    int cnt;
    A = a; B = b; in_valid = 1'b1;
    cnt = 0;
    while (in_ready !== 1'b1 && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_wait in_ready=%b expected=1", in_ready);
    end
    @(posedge clk); #1;  // accept edge
    in_valid = 1'($urandom_range(0, 1));
    A = rand_a();
    B = BW'($urandom());
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1; cnt++;
      in_valid = 1'($urandom_range(0, 1));
    end
    lat = cnt;
    d = Diff; bo = Borrow; z = Zero;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    post_rdy = in_ready;
    post_vld = out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, Borrow, Zero} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_flags got={rdy,vld,bo,z}=%b expected=1000", {in_ready, out_valid, Borrow, Zero});
    end
    checks++;
    if (Diff !== '0) begin
      failures++;
      $display("FAIL reset_diff got=%h expected=0", Diff);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [AW-1:0] ta[4];
    logic [BW-1:0] tb[4];
    logic [AW+1:0] e;
    logic [AW-1:0] d;
    logic          bo, z, pr, pv;
    int            lat;
    ta[0] = 54'd1000;  tb[0] = 9'd1;
    ta[1] = 54'h200;   tb[1] = 9'h1FF;
    ta[2] = 54'd0;     tb[2] = 9'd1;
    ta[3] = 54'h1FF;   tb[3] = 9'h1FF;
    for (int i = 0; i < 4; i++) begin
      e = ref_model(ta[i], tb[i]);
      run_op(ta[i], tb[i], 0, d, bo, z, lat, pr, pv);
      checks++;
      if ({bo, z, d} !== e) begin
        failures++;
        $display("FAIL directed_%0d got bo=%b z=%b d=%h expected bo=%b z=%b d=%h",
                 i, bo, z, d, e[AW+1], e[AW], e[AW-1:0]);
      end
      checks++;
      if (lat != NCH) begin
        failures++;
        $display("FAIL latency_%0d got=%0d expected=%0d", i, lat, NCH);
      end
      checks++;
      if (pr !== 1'b1 || pv !== 1'b0) begin
        failures++;
        $display("FAIL release_%0d in_ready=%b out_valid=%b expected 1/0", i, pr, pv);
      end
      if (i == 2) begin
        checks++;
`ifdef CUSTOM_SUB_SATURATE_EN
        if (d !== 54'd0 || bo !== 1'b1 || z !== 1'b1) begin
`else
        if (d !== 54'h3F_FFFF_FFFF_FFFF || bo !== 1'b1 || z !== 1'b0) begin
`endif
          failures++;
          $display("FAIL underflow_literal got d=%h bo=%b z=%b", d, bo, z);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a, d;
    logic [BW-1:0] b;
    logic [AW+1:0] e;
    logic          bo, z, pr, pv;
    int            lat;
    for (int i = 0; i < 24; i++) begin
      b = BW'($urandom());
      case ($urandom_range(0, 3))
        0: a = rand_a();
        1: a = AW'($urandom_range(0, 600));
        2: a = AW'(b);
        default: a = {$urandom_range(0, 1) ? {45{1'b1}} : {45{1'b0}}, 9'($urandom())};
      endcase
      exp_q.push_back(ref_model(a, b));
      run_op(a, b, $urandom_range(0, 3), d, bo, z, lat, pr, pv);
      e = exp_q.pop_front();
      checks++;
      if ({bo, z, d} !== e || lat != NCH) begin
        failures++;
        $display("FAIL random_%0d a=%h b=%h got bo=%b z=%b d=%h lat=%0d expected bo=%b z=%b d=%h lat=%0d",
                 i, a, b, bo, z, d, lat, e[AW+1], e[AW], e[AW-1:0], NCH);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a, d;
    logic [BW-1:0] b;
    logic [AW+1:0] e;
    logic          bo, z, pr, pv;
    int            lat;
    for (int i = 0; i < 4; i++) begin
      a = rand_a();
      b = BW'($urandom());
      e = ref_model(a, b);
      run_op(a, b, 0, d, bo, z, lat, pr, pv);
      checks++;
      if ({bo, z, d} !== e || pr !== 1'b1 || pv !== 1'b0) begin
        failures++;
        $display("FAIL b2b_%0d got bo=%b z=%b d=%h rdy=%b vld=%b expected bo=%b z=%b d=%h rdy=1 vld=0",
                 i, bo, z, d, pr, pv, e[AW+1], e[AW], e[AW-1:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [AW+1:0] e;
    logic [AW+3:0] got;
    int            cnt;
    a = 54'd1000; b = 9'd1;
    e = ref_model(a, b);
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;  // accept (bench is in IDLE here)
    in_valid = 1'b0;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      A = rand_a();
      B = BW'($urandom());
      @(posedge clk); #1;
      got = {out_valid, in_ready, Borrow, Zero, Diff};
      checks++;
      if (got !== {1'b1, 1'b0, e}) begin
        failures++;
        $display("FAIL backpressure_%0d got vld=%b rdy=%b bo=%b z=%b d=%h expected vld=1 rdy=0 bo=%b z=%b d=%h",
                 i, got[AW+3], got[AW+2], got[AW+1], got[AW], got[AW-1:0], e[AW+1], e[AW], e[AW-1:0]);
      end
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_handshake out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_no_second_accept out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [AW-1:0] d;
    logic          bo, z, pr, pv;
    int            lat;
    A = rand_a(); B = BW'($urandom()); in_valid = 1'b1;
    @(posedge clk); #1;  // accept
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;  // three slices done, counter at 3
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_busy in_ready=%b out_valid=%b expected 0/0", in_ready, out_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, Borrow, Zero} !== 4'b1000 || Diff !== '0) begin
      failures++;
      $display("FAIL async_reset got rdy=%b vld=%b bo=%b z=%b d=%h expected 1 0 0 0 0",
               in_ready, out_valid, Borrow, Zero, Diff);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    run_op(54'd5, 9'd2, 0, d, bo, z, lat, pr, pv);
    checks++;
    if (d !== 54'd3 || bo !== 1'b0 || z !== 1'b0 || lat != NCH) begin
      failures++;
      $display("FAIL fresh_after_reset got d=%h bo=%b z=%b lat=%0d expected d=3 bo=0 z=0 lat=%0d",
               d, bo, z, lat, NCH);
    end
  endtask

  // Watchdog: the whole run is a few thousand cycles.
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
